// File: rtl/riego_scheduler_if.sv
// G/R/E link between the irrigation sequencer (master) and the valve controller (slave).
interface riego_scheduler_if;
    logic [1:0] G1;
    logic [1:0] G2;
    logic [3:0] R1;
    logic [3:0] R2;
    logic [1:0] E;

    modport master (output G1, G2, input R1, R2, E);
    modport slave  (input G1, G2, output R1, R2, E);
endinterface

// File: rtl/riego_scheduler.sv
// Walks four irrigation zones in order, holding each valve code for ISSUE + dur*TICKS_PER_UNIT cycles; all outputs registered.
// RIEGO_ACK_CHECK_EN enables valve-acknowledge checking and the FAULT timeout; otherwise ISSUE is a fixed 2 cycles.
module riego_scheduler #(
    parameter int TICKS_PER_UNIT = 10,
    parameter int DUR_W          = 8,
    parameter int ACK_TIMEOUT    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [DUR_W-1:0] dur_1_1,
    input  logic [DUR_W-1:0] dur_1_2,
    input  logic [DUR_W-1:0] dur_2_1,
    input  logic [DUR_W-1:0] dur_2_2,
    riego_scheduler_if.master vif,
    output logic             busy,
    output logic             done,
    output logic             fault,
    output logic [1:0]       zone
);
    localparam int PW = $clog2(TICKS_PER_UNIT + 1);
    localparam int WW = $clog2(ACK_TIMEOUT + 1);
    localparam logic [PW-1:0] PRE_MAX = PW'(TICKS_PER_UNIT - 1);

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_RUN, S_PAUSE, S_DONE, S_FAULT} state_t;

    state_t           state_q, state_d;
    logic [1:0]       zone_q, zone_d;
    logic [DUR_W-1:0] rem_q, rem_d;
    logic [PW-1:0]    pre_q, pre_d;
    logic [WW-1:0]    wait_q, wait_d;
    logic [1:0]       g1_q, g1_d, g2_q, g2_d;
    logic             busy_q, busy_d, done_q, done_d, fault_q, fault_d;

    logic [DUR_W-1:0] dur [4];
    logic             err, ack, issue_ok, issue_timeout, advance;
    logic             first_found, nxt_found;
    logic [1:0]       first_zone, nxt_zone;

    assign dur[0] = dur_1_1;
    assign dur[1] = dur_1_2;
    assign dur[2] = dur_2_1;
    assign dur[3] = dur_2_2;
    assign err    = (vif.E == 2'b00);

    always_comb begin
        ack = 1'b0;
        case (zone_q)
            2'd0: ack = (vif.R1[3:2] == 2'b01);
            2'd1: ack = (vif.R1[1:0] == 2'b01);
            2'd2: ack = (vif.R2[3:2] == 2'b01);
            default: ack = (vif.R2[1:0] == 2'b01);
        endcase
    end

`ifdef RIEGO_ACK_CHECK_EN
    assign issue_ok      = ack;
    assign issue_timeout = (wait_q == WW'(ACK_TIMEOUT - 1));
`else
    logic unused_ack;
    assign unused_ack    = ack;
    assign issue_ok      = (wait_q == WW'(1));
    assign issue_timeout = 1'b0;
`endif

    // Descending scan so the lowest qualifying zone wins.
    always_comb begin
        first_found = 1'b0;
        first_zone  = 2'd0;
        nxt_found   = 1'b0;
        nxt_zone    = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (dur[i] != '0) begin
                first_found = 1'b1;
                first_zone  = 2'(i);
                if (2'(i) > zone_q) begin
                    nxt_found = 1'b1;
                    nxt_zone  = 2'(i);
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        zone_d  = zone_q;
        rem_d   = rem_q;
        pre_d   = pre_q;
        wait_d  = wait_q;
        advance = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (first_found) begin
                        state_d = S_ISSUE;
                        zone_d  = first_zone;
                        rem_d   = dur[first_zone];
                        pre_d   = PRE_MAX;
                        wait_d  = '0;
                    end else begin
                        state_d = S_DONE;
                        zone_d  = 2'd0;
                    end
                end
            end
            S_ISSUE: begin
                if (err) begin
                    state_d = S_PAUSE;
                end else if (issue_ok) begin
                    // remaining==0 only after a pause taken on the final wrap
                    if (rem_q == '0) advance = 1'b1;
                    else             state_d = S_RUN;
                end else if (issue_timeout) begin
                    state_d = S_FAULT;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            S_RUN: begin
                if (pre_q == '0) begin
                    pre_d = PRE_MAX;
                    rem_d = rem_q - 1'b1;
                end else begin
                    pre_d = pre_q - 1'b1;
                end
                if (err)                                        state_d = S_PAUSE;
                else if (pre_q == '0 && rem_q == DUR_W'(1))     advance = 1'b1;
            end
            S_PAUSE: begin
                if (!err) begin
                    state_d = S_ISSUE;
                    wait_d  = '0;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = state_q;
        endcase

        if (advance) begin
            if (nxt_found) begin
                state_d = S_ISSUE;
                zone_d  = nxt_zone;
                rem_d   = dur[nxt_zone];
                pre_d   = PRE_MAX;
                wait_d  = '0;
            end else begin
                state_d = S_DONE;
            end
        end

        if (abort) begin
            state_d = S_IDLE;
            zone_d  = 2'd0;
            rem_d   = '0;
            pre_d   = '0;
            wait_d  = '0;
        end

        g1_d = 2'b00;
        g2_d = 2'b00;
        if (state_d == S_ISSUE || state_d == S_RUN) begin
            case (zone_d)
                2'd0: g1_d = 2'b01;
                2'd1: g1_d = 2'b10;
                2'd2: g2_d = 2'b01;
                default: g2_d = 2'b10;
            endcase
        end
        busy_d  = (state_d == S_ISSUE) || (state_d == S_RUN) ||
                  (state_d == S_PAUSE) || (state_d == S_DONE);
        done_d  = (state_d == S_DONE);
        fault_d = (state_d == S_FAULT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            zone_q  <= 2'd0;
            rem_q   <= '0;
            pre_q   <= '0;
            wait_q  <= '0;
            g1_q    <= 2'b00;
            g2_q    <= 2'b00;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            zone_q  <= zone_d;
            rem_q   <= rem_d;
            pre_q   <= pre_d;
            wait_q  <= wait_d;
            g1_q    <= g1_d;
            g2_q    <= g2_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            fault_q <= fault_d;
        end
    end

    assign vif.G1 = g1_q;
    assign vif.G2 = g2_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign fault  = fault_q;
    assign zone   = zone_q;
endmodule

// File: tb/tb_riego_scheduler.sv
// Self-checking bench: per-cycle expected outputs derived from zone durations and timing rules, compared against the sequencer.
module tb_riego_scheduler;
    localparam int T = 2;

    typedef struct {
        logic [1:0] g1;
        logic [1:0] g2;
        logic       busy;
        logic       done;
        logic       fault;
        int         zone;   // -1: not compared
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] dur_1_1 = '0, dur_1_2 = '0, dur_2_1 = '0, dur_2_2 = '0;
    logic       busy, done, fault;
    logic [1:0] zone;
    logic       no_ack = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;
    exp_t exp_q[$];

    riego_scheduler_if vif ();

    riego_scheduler #(.TICKS_PER_UNIT(T), .DUR_W(8), .ACK_TIMEOUT(4)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .dur_1_1(dur_1_1), .dur_1_2(dur_1_2), .dur_2_1(dur_2_1), .dur_2_2(dur_2_2),
        .vif(vif.master),
        .busy(busy), .done(done), .fault(fault), .zone(zone)
    );

    always #5 clk = ~clk;

    // Valve controller: one-edge lag from request code to valve output.
    always @(posedge clk) begin
        if (reset || no_ack) begin
            vif.R1 <= 4'b0000;
            vif.R2 <= 4'b0000;
        end else begin
            vif.R1 <= {(vif.G1 == 2'b01) ? 2'b01 : 2'b00, (vif.G1 == 2'b10) ? 2'b01 : 2'b00};
            vif.R2 <= {(vif.G2 == 2'b01) ? 2'b01 : 2'b00, (vif.G2 == 2'b10) ? 2'b01 : 2'b00};
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic void push_n(int n, logic [1:0] g1, logic [1:0] g2,
                                   logic b, logic d, logic f, int z);
        exp_t e;
        e.g1 = g1; e.g2 = g2; e.busy = b; e.done = d; e.fault = f; e.zone = z;
        for (int i = 0; i < n; i++) exp_q.push_back(e);
    endfunction

    // Uninterrupted program: each nonzero zone shows its code for 2 + dur*T cycles.
    function automatic void model_prog(int d0, int d1, int d2, int d3);
        int d[4];
        logic [1:0] c1[4];
        logic [1:0] c2[4];
        d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
        c1[0] = 2'b01; c1[1] = 2'b10; c1[2] = 2'b00; c1[3] = 2'b00;
        c2[0] = 2'b00; c2[1] = 2'b00; c2[2] = 2'b01; c2[3] = 2'b10;
        for (int z = 0; z < 4; z++)
            if (d[z] > 0) push_n(2 + d[z] * T, c1[z], c2[z], 1'b1, 1'b0, 1'b0, z);
        push_n(1, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0, -1);
        push_n(1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, -1);
    endfunction

    task automatic run_seq(input string name, input int d0, input int d1, input int d2, input int d3,
                           input int e_lo, input int e_hi, input int abort_at, input int rst_at,
                           input bit noisy);
        exp_t e;
        int   j;
        dur_1_1 = 8'(d0); dur_1_2 = 8'(d1); dur_2_1 = 8'(d2); dur_2_2 = 8'(d3);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        j = 1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check($sformatf("%s outs w%0d", name, j),
                  32'({vif.G1, vif.G2, busy, done, fault}),
                  32'({e.g1, e.g2, e.busy, e.done, e.fault}));
            if (e.zone >= 0)
                check($sformatf("%s zone w%0d", name, j), 32'(zone), 32'(e.zone));
            vif.E = (j >= e_lo && j <= e_hi) ? 2'b00 : 2'b11;
            abort = (j == abort_at);
            reset = (j == rst_at);
            start = (noisy && exp_q.size() > 0 && (abort_at == 0 || j <= abort_at))
                    ? 1'($urandom_range(0, 1)) : 1'b0;
            @(posedge clk); #1;
            j++;
        end
        vif.E = 2'b11; abort = 1'b0; reset = 1'b0; start = 1'b0;
    endtask

    initial begin
        int d[4];
        vif.E = 2'b11;
        repeat (2) @(posedge clk);
        #1;
        check("reset outs", 32'({vif.G1, vif.G2, busy, done, fault}), 32'd0);
        check("reset zone", 32'(zone), 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Reference program: 3,0,1,0
        model_prog(3, 0, 1, 0);
        run_seq("prog3010", 3, 0, 1, 0, 0, -1, 0, 0, 1'b0);

        // All durations zero
        model_prog(0, 0, 0, 0);
        run_seq("allzero", 0, 0, 0, 0, 0, -1, 0, 0, 1'b0);

        // Random programs with start toggling while busy
        for (int k = 0; k < 10; k++) begin
            for (int z = 0; z < 4; z++) d[z] = int'($urandom_range(0, 3));
            model_prog(d[0], d[1], d[2], d[3]);
            run_seq($sformatf("rand%0d", k), d[0], d[1], d[2], d[3], 0, -1, 0, 0, 1'b1);
        end

        // Level error on the 3->2 unit wrap of zone 0, held 5 cycles
        push_n(4, 2'b01, 2'b00, 1'b1, 1'b0, 1'b0, 0);
        push_n(5, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 0);
        push_n(2 + 2 * T, 2'b01, 2'b00, 1'b1, 1'b0, 1'b0, 0);
        push_n(2 + 1 * T, 2'b00, 2'b01, 1'b1, 1'b0, 1'b0, 2);
        push_n(1, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0, -1);
        push_n(1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, -1);
        run_seq("pause", 3, 0, 1, 0, 4, 8, 0, 0, 1'b0);

        // Abort mid-RUN of zone 2
        push_n(2 + 1 * T, 2'b01, 2'b00, 1'b1, 1'b0, 1'b0, 0);
        push_n(4, 2'b00, 2'b01, 1'b1, 1'b0, 1'b0, 2);
        push_n(3, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 0);
        run_seq("abort", 1, 0, 3, 0, 0, -1, 8, 0, 1'b0);

        // Reset mid-ISSUE, then a fresh run from zone 0
        push_n(2, 2'b01, 2'b00, 1'b1, 1'b0, 1'b0, 0);
        push_n(2, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 0);
        run_seq("rstmid", 2, 1, 0, 0, 0, -1, 0, 2, 1'b0);
        model_prog(2, 1, 0, 0);
        run_seq("afterrst", 2, 1, 0, 0, 0, -1, 0, 0, 1'b0);

`ifdef RIEGO_ACK_CHECK_EN
        // Controller never acknowledges: timeout into FAULT, start ignored, abort clears
        no_ack = 1'b1;
        push_n(4, 2'b01, 2'b00, 1'b1, 1'b0, 1'b0, 0);
        push_n(4, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 0);
        push_n(1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 0);
        run_seq("noack", 1, 0, 0, 0, 0, -1, 8, 0, 1'b1);
        no_ack = 1'b0;
        @(posedge clk); #1;
        model_prog(1, 1, 0, 0);
        run_seq("postfault", 1, 1, 0, 0, 0, -1, 0, 0, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/riego_scheduler.md
# riego_scheduler

Irrigation program sequencer that drives the zone-request inputs (G1, G2) of the irrigation valve controller and reads back its valve outputs (R1, R2) and error flag (E). On a start pulse it walks the four valves in fixed order and holds each open for a programmed number of time units. It confirms each valve actually opened and pauses while the controller reports a water-level error. It sits between the user/program registers and the valve controller, acting as the requesting end of the G/R/E interface.

## Interface
- TICKS_PER_UNIT, 10: clk cycles per duration unit (≥1).
- DUR_W, 8: width of each duration field.
- ACK_TIMEOUT, 4: max cycles in ISSUE waiting for valve acknowledge (≥2).

- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  program start; sampled only in IDLE.
- abort  in  1  return to IDLE from any state.
- dur_1_1, dur_1_2, dur_2_1, dur_2_2  in  DUR_W each  zone durations in units; 0 = skip zone.
- R1, R2  in  4 each  controller valve outputs; {v_x_1[1:0], v_x_2[1:0]}, 2'b01 = water, 2'b00 = stop.
- E  in  2  controller error; 2'b00 = level error, otherwise no error.
- G1, G2  out  2 each  zone request codes (registered).
- busy  out  1  high from ISSUE through DONE, including PAUSE.
- done  out  1  one-cycle pulse at program completion.
- fault  out  1  sticky acknowledge-timeout flag.
- zone  out  2  current zone index 0..3.

## Operation
- Zone order and code: 0 → G1=01 (ack R1[3:2]==01); 1 → G1=10 (ack R1[1:0]==01); 2 → G2=01 (ack R2[3:2]==01); 3 → G2=10 (ack R2[1:0]==01). Unselected G is 00.
- States: IDLE, ISSUE, RUN, PAUSE, DONE, FAULT.
- IDLE: G=00. If start=1, go to ISSUE for the first zone with nonzero duration, and load the unit counter. If all durations are 0, go to DONE.
- ISSUE: drive the zone code and count wait cycles. E==00 → PAUSE (priority). Ack sampled → RUN. Wait count reaching ACK_TIMEOUT without ack → FAULT.
- RUN: drive the zone code. The prescaler counts TICKS_PER_UNIT−1..0, and each wrap decrements the remaining units. When remaining hits 0, go to ISSUE for the next nonzero zone, or to DONE if none remain. E==00 → PAUSE.
- PAUSE: G=00, prescaler and remaining units frozen. When E≠00, return to ISSUE for the same zone without reloading duration, and restart the ack wait count.
- DONE: G=00, done=1 for one cycle, then IDLE.
- FAULT: G=00, fault=1. Held until abort or reset. start is ignored.
- abort: in any state, next state is IDLE with G=00. fault clears and counters clear. abort has priority over all other events.
- Durations are sampled when each zone is entered fresh. Changes mid-zone do not affect the running zone.
- Reset values: G1=G2=00, busy=0, done=0, fault=0, zone=0, state IDLE.

## Timing
- Registered outputs: G appears the cycle after the decision edge.
- The controller updates its state one edge after G changes, so ack normally arrives in the 2nd ISSUE cycle.
- Each zone holds its code for ISSUE cycles + dur×TICKS_PER_UNIT cycles. There is no G=00 gap between consecutive zones.
- start in the cycle before abort or reset has no effect. Reset mid-program is equivalent to abort.
- start while busy: ignored.
- E error and ack in the same ISSUE cycle: PAUSE wins.
- E error in the same cycle as the final unit wrap: PAUSE wins, with remaining=0. On resume, ISSUE + ack leads immediately to advance.

## Configuration
- RIEGO_ACK_CHECK_EN defined: acknowledge checking and FAULT as above.
- RIEGO_ACK_CHECK_EN undefined: ISSUE lasts exactly 2 cycles and then goes to RUN regardless of R. FAULT is unreachable and fault is tied 0. PAUSE behaviour is unchanged.

## Test plan
- TICKS_PER_UNIT=2, durations 3,0,1,0, and a controller model with 1-edge lag. Start at cycle 0 → G1=01 for cycles 1–8, G2=01 for cycles 9–12, done=1 at cycle 13, busy high cycles 1–13, zones 1/3 skipped.
- All durations 0, start → done pulse the cycle after start. G stays 00 and busy is high for exactly one cycle.
- Controller model never acks, ACK_TIMEOUT=4 → G1=01 for 4 cycles, then G=00 and fault=1 held. start is ignored. abort clears fault the next cycle.
- In RUN zone 0 with 2 units remaining, force E=00 for 5 cycles → G=00 during the pause, then G1=01 is reissued. After ack, exactly 2×TICKS_PER_UNIT RUN cycles elapse before G moves to the next zone.
- abort asserted mid-RUN zone 2 → G=00, busy=0, zone=0 the next cycle, and no done pulse.
- Reset asserted mid-ISSUE → all outputs at reset values the next cycle. A new start then runs the program from zone 0.
